// File: rtl/sync_down_timer_4bit_pkg.sv
// Shared definitions for the 4-bit down timer:
// FSM state encodings and the default counter width.
package sync_down_timer_4bit_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_down_timer_4bit_core.sv
// Down-counter register: load / decrement / hold, plus is_one flag.
// Ports: clk, rst (async high), ld, ld_val, dec -> q, is_one.
module sync_down_timer_4bit_core
    import sync_down_timer_4bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             is_one
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Decrement is refused at zero so the count can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (dec && (q != '0)) begin
            q <= q - ONE;
        end
    end

    assign is_one = (q == ONE);

endmodule

// File: rtl/sync_down_timer_4bit.sv
// Loadable down timer: counts a preset to zero, pulses tc once.
// Ports: clk, rst (async high), load, load_val, start, stop, en
//        -> q (count), tc (registered pulse), busy (state==RUN).
// Build option: define AUTO_RELOAD_EN for periodic reload mode.
module sync_down_timer_4bit
    import sync_down_timer_4bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] reload_r;
    logic [WIDTH-1:0] core_val;
    logic             core_ld;
    logic             dec;
    logic             is_one;
    logic             run;
    logic             hit;

    assign run = (state == ST_RUN);

    // Terminal edge: enabled RUN cycle at q==1, not pre-empted
    // by load or stop.
    assign hit = run && !load && !stop && en && is_one;
    assign dec = run && !load && !stop && en;

    // Reload value feeds the same mux as load_val; it is only
    // ever selected when periodic reload is built in.
    assign core_val = load ? load_val : reload_r;
`ifdef AUTO_RELOAD_EN
    assign core_ld = load || hit;
`else
    assign core_ld = load;
`endif

    sync_down_timer_4bit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .ld     (core_ld),
        .ld_val (core_val),
        .dec    (dec),
        .q      (q),
        .is_one (is_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_r <= '0;
        end else if (load) begin
            reload_r <= load_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc <= 1'b0;
        end else begin
            tc <= hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (!load && !stop && start && (q != '0)) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load || stop) begin
                    state_nx = ST_IDLE;
                end else if (hit) begin
`ifdef AUTO_RELOAD_EN
                    state_nx = ST_RUN;
`else
                    state_nx = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
    end

endmodule

// File: tb/tb_sync_down_timer_4bit.sv
// Self-checking bench for sync_down_timer_4bit: vector table,
// corner sequences and randomized run against a rule-level model.
module tb_sync_down_timer_4bit;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       st;
        logic       sp;
        logic       en;
        logic [3:0] q;
        logic       tc;
        logic       busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       en = 1'b0;
    logic [3:0] q;
    logic       tc;
    logic       busy;

    int tests = 0;
    int fails = 0;

    // reference model state
    int mq;
    int mrel;
    bit mrun;
    bit mdone;
    bit mtc;

    vec_t tbl[$];

    sync_down_timer_4bit dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .q        (q),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, act, exp);
        end
    endtask

    task automatic exp3(input string nm, input int eq,
                        input bit etc, input bit eb);
        chk({nm, "_q"}, {4'd0, q}, 8'(eq));
        chk({nm, "_tc"}, {7'd0, tc}, {7'd0, etc});
        chk({nm, "_busy"}, {7'd0, busy}, {7'd0, eb});
    endtask

    task automatic drive(input bit l, input int lv,
                         input bit s, input bit p, input bit e);
        load = l;
        load_val = 4'(lv);
        start = s;
        stop = p;
        en = e;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input bit l, input int lv,
                                input bit s, input bit p,
                                input bit e, input int eq,
                                input bit etc, input bit eb);
        vec_t v;
        v.ld = l;
        v.lv = 4'(lv);
        v.st = s;
        v.sp = p;
        v.en = e;
        v.q = 4'(eq);
        v.tc = etc;
        v.busy = eb;
        return v;
    endfunction

    // Model step from the behavioural rules, priority
    // load > stop > start > en.
    task automatic model(input bit l, input int lv,
                         input bit s, input bit p, input bit e);
        mtc = 0;
        if (l) begin
            mq = lv;
            mrel = lv;
            mrun = 0;
            mdone = 0;
        end else if (mdone) begin
            mdone = 0;
        end else if (mrun) begin
            if (p) begin
                mrun = 0;
            end else if (e) begin
                if (mq > 1) begin
                    mq = mq - 1;
                end else begin
                    mtc = 1;
`ifdef AUTO_RELOAD_EN
                    mq = mrel;
`else
                    mq = 0;
                    mrun = 0;
                    mdone = 1;
`endif
                end
            end
        end else if (!p && s && mq != 0) begin
            mrun = 1;
        end
    endtask

    initial begin
        #1;
        exp3("reset", 0, 0, 0);
        #9;
        rst = 1'b0;

`ifndef AUTO_RELOAD_EN
        // one-shot from 4
        tbl.push_back(mk(1, 4, 0, 0, 0, 4, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
        // enable gating from 3
        tbl.push_back(mk(1, 3, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        // load 0 then start: no effect
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
        // load with start: load wins
        tbl.push_back(mk(1, 5, 1, 0, 0, 5, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 0, 0));
        // load during run at q=2
        tbl.push_back(mk(0, 0, 1, 0, 0, 5, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 0, 1));
        tbl.push_back(mk(1, 7, 1, 0, 1, 7, 0, 0));
        // stop / resume from 9
        tbl.push_back(mk(1, 9, 0, 0, 0, 9, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 9, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 8, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 7, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 6, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 6, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 6, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].ld, int'(tbl[i].lv), tbl[i].st,
                  tbl[i].sp, tbl[i].en);
            exp3($sformatf("vec%0d", i), int'(tbl[i].q),
                 tbl[i].tc, tbl[i].busy);
        end

        // full-width preset: 15 enabled cycles to tc
        drive(1, 15, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            drive(0, 0, 0, 0, 1);
            exp3($sformatf("w15_%0d", i), (i >= 15) ? 0 : 15 - i,
                 i == 15, i < 15);
        end
`else
        // periodic reload from 3
        drive(1, 3, 0, 0, 0);
        exp3("ar_load", 3, 0, 0);
        drive(0, 0, 1, 0, 0);
        exp3("ar_start", 3, 0, 1);
        for (int i = 1; i <= 9; i++) begin
            drive(0, 0, 0, 0, 1);
            exp3($sformatf("ar_%0d", i), 3 - (i % 3),
                 (i % 3) == 0, 1);
        end
        drive(0, 0, 0, 1, 0);
        exp3("ar_stop", 3, 0, 0);
`endif

        // async reset mid-count at q=5
        drive(1, 5, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        exp3("pre_rst", 5, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        exp3("async_rst", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        mq = 0;
        mrel = 0;
        mrun = 0;
        mdone = 0;
        mtc = 0;
        for (int i = 0; i < 400; i++) begin
            bit l, s, p, e;
            int lv;
            l = ($urandom_range(0, 7) == 0);
            lv = int'($urandom_range(0, 15));
            s = ($urandom_range(0, 2) == 0);
            p = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 3) != 0);
            model(l, lv, s, p, e);
            drive(l, lv, s, p, e);
            exp3($sformatf("rnd%0d", i), mq, mtc, mrun);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
